// File: rtl/y86_pkg.sv
// y86_pkg: shared icode, OPq function and condition constants, plus the condition-code decoder
// Contents: I_* icodes, ALU_* OPq ifuns, C_* condition ifuns, cond_eval(ifun, zf, sf, of)
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    function automatic logic cond_eval(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
        return fn == C_YES ? 1'b1 :
               fn == C_LE  ? (sf ^ of) | zf :
               fn == C_L   ? sf ^ of :
               fn == C_E   ? zf :
               fn == C_NE  ? ~zf :
               fn == C_GE  ? ~(sf ^ of) :
               fn == C_G   ? ~(sf ^ of) & ~zf : 1'b0;
    endfunction
endpackage

// File: rtl/y86_alu.sv
// y86_alu: combinational OPq ALU computing b op a and the resulting zero/sign/overflow flags
// Ports: ifun (op select), a/b (operands), res (result), legal (ifun is a real op), zf/sf/of (flags)
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   ifun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         legal,
    output logic         zf,
    output logic         sf,
    output logic         of
);
    always_comb begin
        legal = ifun <= ALU_XOR;
        res = ifun == ALU_ADD ? b + a :
              ifun == ALU_SUB ? b - a :
              ifun == ALU_AND ? b & a :
              ifun == ALU_XOR ? b ^ a : '0;
        zf = res == '0;
        sf = res[W-1];
        of = ifun == ALU_ADD ? (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]) :
             ifun == ALU_SUB ? (a[W-1] != b[W-1]) && (res[W-1] != b[W-1]) : 1'b0;
    end
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: Y86 execute stage with registered valE/Cnd/icode outputs and the condition-code register
// Ports: clk, rst (async, active-high); in_valid/icode/ifun/valA/valB/valC (instruction in);
//        stall (hold everything), bubble (load a nop); out_valid/out_icode/valE/Cnd (registered result);
//        cc_zf/cc_sf/cc_of (condition codes)
module execute_pipe
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    input  logic         stall,
    input  logic         bubble,
    output logic         out_valid,
    output logic [3:0]   out_icode,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);
    localparam logic [W-1:0] STEP = W'(W / 8);

    logic [W-1:0] alu_res;
    logic         alu_legal;
    logic         alu_zf;
    logic         alu_sf;
    logic         alu_of;
    logic [W-1:0] e_val;
    logic         e_cnd;
    logic         go;

    y86_alu #(.W(W)) u_alu (
        .ifun (ifun),
        .a    (valA),
        .b    (valB),
        .res  (alu_res),
        .legal(alu_legal),
        .zf   (alu_zf),
        .sf   (alu_sf),
        .of   (alu_of)
    );

    always_comb begin
        go = in_valid & ~bubble;
        e_val = icode == I_RRMOVQ ? valA :
                icode == I_IRMOVQ ? valC :
                (icode == I_RMMOVQ || icode == I_MRMOVQ) ? valB + valC :
                icode == I_OPQ ? alu_res :
                (icode == I_CALL || icode == I_PUSHQ) ? valB - STEP :
                (icode == I_RET || icode == I_POPQ) ? valB + STEP : '0;
        // Uses the CC currently held, i.e. the value written by the previous instruction
        e_cnd = (icode == I_RRMOVQ || icode == I_JXX) && cond_eval(ifun, cc_zf, cc_sf, cc_of);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= I_NOP;
            valE      <= '0;
            Cnd       <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
        end else if (!stall) begin
            out_valid <= go;
            out_icode <= go ? icode : I_NOP;
            valE      <= go ? e_val : '0;
            Cnd       <= go & e_cnd;
            if (go && icode == I_OPQ && alu_legal) begin
                cc_zf <= alu_zf;
                cc_sf <= alu_sf;
                cc_of <= alu_of;
            end
        end
    end
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed vector table plus hand sequences for stall, reset and W=32 stack ops
module tb_execute_pipe;
    typedef struct {
        int          iv;
        int          ic;
        int          fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        int          st;
        int          bu;
        int          ev;
        int          ei;
        logic [63:0] ee;
        int          ec;
        int          ez;
        int          es;
        int          eo;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        stall;
    logic        bubble;
    logic        out_valid;
    logic [3:0]  out_icode;
    logic [63:0] valE;
    logic        Cnd;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;
    logic        out_valid32;
    logic [3:0]  out_icode32;
    logic [31:0] valE32;
    logic        cnd32;
    logic        zf32;
    logic        sf32;
    logic        of32;

    int total = 0;
    int bad = 0;
    vec_t tv[$];

    execute_pipe #(.W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC), .stall(stall), .bubble(bubble),
        .out_valid(out_valid), .out_icode(out_icode), .valE(valE), .Cnd(Cnd),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    execute_pipe #(.W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .valA(valA[31:0]), .valB(valB[31:0]), .valC(valC[31:0]), .stall(stall), .bubble(bubble),
        .out_valid(out_valid32), .out_icode(out_icode32), .valE(valE32), .Cnd(cnd32),
        .cc_zf(zf32), .cc_sf(sf32), .cc_of(of32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [72:0] got, input logic [72:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {valid,icode,valE,cnd,zf,sf,of}=%h want %h", name, got, exp);
        end
    endtask

    function automatic logic [72:0] outs();
        return {out_valid, out_icode, valE, Cnd, cc_zf, cc_sf, cc_of};
    endfunction

    task automatic drive(input int iv, input int ic, input int fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input int st, input int bu);
        in_valid = 1'(iv);
        icode    = 4'(ic);
        ifun     = 4'(fn);
        valA     = a;
        valB     = b;
        valC     = c;
        stall    = 1'(st);
        bubble   = 1'(bu);
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [72:0] RST_VALS = {1'b0, 4'h1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        //               iv ic fn  a          b          c       st bu  ev ei  valE              cnd zf sf of
        tv.push_back('{1, 6, 0, 64'd120,   64'd12,    64'd0,  0, 0, 1, 6, 64'd132,           0, 0, 0, 0});
        tv.push_back('{1, 6, 0, 64'd1,     MAXP,      64'd0,  1, 0, 1, 6, 64'd132,           0, 0, 0, 0});
        tv.push_back('{1, 6, 0, 64'd1,     MAXP,      64'd0,  1, 0, 1, 6, 64'd132,           0, 0, 0, 0});
        tv.push_back('{1, 6, 0, 64'd1,     MAXP,      64'd0,  1, 1, 1, 6, 64'd132,           0, 0, 0, 0});
        tv.push_back('{1, 6, 0, 64'd1,     MAXP,      64'd0,  0, 0, 1, 6, MINN,              0, 0, 1, 1});
        tv.push_back('{1, 7, 2, 64'd0,     64'd0,     64'h40, 0, 0, 1, 7, 64'd0,             0, 0, 1, 1});
        tv.push_back('{1, 7, 5, 64'd0,     64'd0,     64'h40, 0, 0, 1, 7, 64'd0,             1, 0, 1, 1});
        tv.push_back('{1, 7, 1, 64'd0,     64'd0,     64'h40, 0, 0, 1, 7, 64'd0,             0, 0, 1, 1});
        tv.push_back('{1, 6, 1, 64'd35,    64'd35,    64'd0,  0, 0, 1, 6, 64'd0,             0, 1, 0, 0});
        tv.push_back('{1, 2, 4, 64'd7,     64'd0,     64'd0,  0, 0, 1, 2, 64'd7,             0, 1, 0, 0});
        tv.push_back('{1, 7, 3, 64'd0,     64'd0,     64'd0,  0, 0, 1, 7, 64'd0,             1, 1, 0, 0});
        tv.push_back('{1, 6, 0, 64'd1,     64'd1,     64'd0,  0, 1, 0, 1, 64'd0,             0, 1, 0, 0});
        tv.push_back('{0, 6, 0, 64'd1,     64'd1,     64'd0,  0, 0, 0, 1, 64'd0,             0, 1, 0, 0});
        tv.push_back('{1, 6, 2, 64'hF0,    64'hFF,    64'd0,  0, 0, 1, 6, 64'hF0,            0, 0, 0, 0});
        tv.push_back('{1, 6, 3, ONES,      64'h0F,    64'd0,  0, 0, 1, 6, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 0});
        tv.push_back('{1, 7, 2, 64'd0,     64'd0,     64'd0,  0, 0, 1, 7, 64'd0,             1, 0, 1, 0});
        tv.push_back('{1, 7, 6, 64'd0,     64'd0,     64'd0,  0, 0, 1, 7, 64'd0,             0, 0, 1, 0});
        tv.push_back('{1, 7, 7, 64'd0,     64'd0,     64'd0,  0, 0, 1, 7, 64'd0,             0, 0, 1, 0});
        tv.push_back('{1, 6, 4, 64'd5,     64'd6,     64'd0,  0, 0, 1, 6, 64'd0,             0, 0, 1, 0});
        tv.push_back('{1, 2, 0, 64'hABCD,  64'd0,     64'd0,  0, 0, 1, 2, 64'hABCD,          1, 0, 1, 0});
        tv.push_back('{1, 3, 0, 64'd0,     64'd0,     64'h1234, 0, 0, 1, 3, 64'h1234,        0, 0, 1, 0});
        tv.push_back('{1, 4, 0, 64'd0,     64'h10,    64'h8,  0, 0, 1, 4, 64'h18,            0, 0, 1, 0});
        tv.push_back('{1, 5, 0, 64'd0,     ONES,      64'd2,  0, 0, 1, 5, 64'd1,             0, 0, 1, 0});
        tv.push_back('{1, 8, 0, 64'd0,     64'h100,   64'd0,  0, 0, 1, 8, 64'hF8,            0, 0, 1, 0});
        tv.push_back('{1, 9, 0, 64'd0,     64'h100,   64'd0,  0, 0, 1, 9, 64'h108,           0, 0, 1, 0});
        tv.push_back('{1, 10, 0, 64'd0,    64'd0,     64'd0,  0, 0, 1, 10, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 0});
        tv.push_back('{1, 11, 0, 64'd0,    64'h100,   64'd0,  0, 0, 1, 11, 64'h108,          0, 0, 1, 0});
        tv.push_back('{1, 6, 1, 64'd1,     MINN,      64'd0,  0, 0, 1, 6, MAXP,              0, 0, 0, 1});
        tv.push_back('{1, 0, 0, 64'd3,     64'd3,     64'd3,  0, 0, 1, 0, 64'd0,             0, 0, 0, 1});
        tv.push_back('{1, 2, 2, 64'd9,     64'd0,     64'd0,  0, 0, 1, 2, 64'd9,             1, 0, 0, 1});
        tv.push_back('{1, 1, 0, 64'd9,     64'd9,     64'd9,  0, 0, 1, 1, 64'd0,             0, 0, 0, 1});

        rst = 1'b1;
        drive(0, 1, 0, 64'd0, 64'd0, 64'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk("reset_state", outs(), RST_VALS);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].iv, tv[i].ic, tv[i].fn, tv[i].a, tv[i].b, tv[i].c, tv[i].st, tv[i].bu);
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), outs(),
                   {1'(tv[i].ev), 4'(tv[i].ei), tv[i].ee, 1'(tv[i].ec),
                    1'(tv[i].ez), 1'(tv[i].es), 1'(tv[i].eo)});
            @(negedge clk);
        end

        drive(1, 10, 0, 64'd0, 64'h100, 64'd0, 0, 0);
        @(posedge clk);
        #1 chk("push_w32", {69'd0, 4'(out_icode32)} | {41'd0, valE32}, {41'd0, 32'hFC} | {69'd0, 4'hA});
        @(negedge clk);
        drive(1, 11, 0, 64'd0, 64'h100, 64'd0, 0, 0);
        @(posedge clk);
        #1 chk("pop_w32", {41'd0, valE32}, {41'd0, 32'h104});
        @(negedge clk);

        drive(1, 6, 0, 64'd1, MAXP, 64'd0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 6, 1, 64'd5, 64'd5, 64'd0, 1, 0);
        #2 rst = 1'b1;
        #1 chk("reset_async_mid_stall", outs(), RST_VALS);
        @(posedge clk);
        #1 chk("reset_held_over_edge", outs(), RST_VALS);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 6, 0, 64'd120, 64'd12, 64'd0, 0, 0);
        @(posedge clk);
        #1 chk("first_edge_after_reset", outs(), {1'b1, 4'h6, 64'd132, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
